// File: rtl/alien_params.sv
// Shared constants for the alien row blocks: sprite/grid geometry, colour codes,
// VGA field widths and the drawer state encoding.
package alien_params;

  localparam int unsigned ALIEN_W_DEF    = 4;
  localparam int unsigned ALIEN_H_DEF    = 4;
  localparam int unsigned NUM_ALIENS_DEF = 8;
  localparam int unsigned SPACING_DEF    = 16;
  localparam int unsigned X_ORIGIN_DEF   = 16;
  localparam int unsigned Y_OFFSET_DEF   = 8;

  localparam logic [2:0] ALIEN_COLOUR_DEF = 3'b010;
  localparam logic [2:0] BG_COLOUR_DEF    = 3'b000;

  localparam int unsigned X_W      = 8;
  localparam int unsigned Y_W      = 7;
  localparam int unsigned ROW_W    = 6;
  localparam int unsigned COLOUR_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ERASE = 2'd1,
    DRAW  = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pixel_scanner.sv
// Nested cx/cy/a sprite scan counter. The _c outputs are the index that will be
// current after the next clock edge, so the caller can register pixel addresses.
module pixel_scanner
  import alien_params::*;
#(
  parameter int unsigned COLS  = ALIEN_W_DEF,
  parameter int unsigned ROWS  = ALIEN_H_DEF,
  parameter int unsigned COUNT = NUM_ALIENS_DEF,
  localparam int unsigned CX_W = cnt_w(COLS),
  localparam int unsigned CY_W = cnt_w(ROWS),
  localparam int unsigned A_W  = cnt_w(COUNT)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            step,
  output logic [CX_W-1:0] cx_c,
  output logic [CY_W-1:0] cy_c,
  output logic [A_W-1:0]  a_c,
  output logic            last_c
);

  logic [CX_W-1:0] cx;
  logic [CY_W-1:0] cy;
  logic [A_W-1:0]  a;

  // cx runs fastest, then cy, then the alien index.
  always_comb begin
    cx_c = cx;
    cy_c = cy;
    a_c  = a;
    if (start) begin
      cx_c = '0;
      cy_c = '0;
      a_c  = '0;
    end else if (step) begin
      if (cx == CX_W'(COLS - 1)) begin
        cx_c = '0;
        if (cy == CY_W'(ROWS - 1)) begin
          cy_c = '0;
          a_c  = a + A_W'(1);
        end else begin
          cy_c = cy + CY_W'(1);
        end
      end else begin
        cx_c = cx + CX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cx <= '0;
      cy <= '0;
      a  <= '0;
    end else begin
      cx <= cx_c;
      cy <= cy_c;
      a  <= a_c;
    end
  end

  assign last_c = (cx == CX_W'(COLS - 1)) && (cy == CY_W'(ROWS - 1)) &&
                  (a == A_W'(COUNT - 1));

endmodule

// File: rtl/alien_row_drawer.sv
// Erases the previous alien row and draws it at the new fall-counter row, one VGA
// pixel per cycle; on game over the row is erased once and left blank.
module alien_row_drawer
  import alien_params::*;
#(
  parameter int unsigned ALIEN_W      = ALIEN_W_DEF,
  parameter int unsigned ALIEN_H      = ALIEN_H_DEF,
  parameter int unsigned NUM_ALIENS   = NUM_ALIENS_DEF,
  parameter int unsigned SPACING      = SPACING_DEF,
  parameter int unsigned X_ORIGIN     = X_ORIGIN_DEF,
  parameter int unsigned Y_OFFSET     = Y_OFFSET_DEF,
  parameter logic [2:0]  ALIEN_COLOUR = ALIEN_COLOUR_DEF,
  parameter logic [2:0]  BG_COLOUR    = BG_COLOUR_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                drawEn,
  input  logic [ROW_W-1:0]    CounterValue,
  input  logic                gameOver,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                busy,
  output logic                done
);

  localparam int unsigned CX_W = cnt_w(ALIEN_W);
  localparam int unsigned CY_W = cnt_w(ALIEN_H);
  localparam int unsigned A_W  = cnt_w(NUM_ALIENS);

  state_t           state;
  logic             prev_valid;
  logic             pending;
  logic             go_req;
  logic             game_over_d;
  logic             erase_only;
  logic [ROW_W-1:0] prev_y;
  logic [ROW_W-1:0] new_y;
  logic [ROW_W-1:0] pending_y;

  logic [CX_W-1:0]  cx_c;
  logic [CY_W-1:0]  cy_c;
  logic [A_W-1:0]   a_c;
  logic             last_c;
  logic             scan_start;
  logic             scan_step;

  logic             go_hit;
  logic             go_launch;
  logic             draw_launch;
  logic             into_draw;
  logic [ROW_W-1:0] req_y;
  logic [ROW_W-1:0] row;
  logic [X_W-1:0]   pix_x;
  logic [Y_W-1:0]   pix_y;

  pixel_scanner #(
    .COLS  (ALIEN_W),
    .ROWS  (ALIEN_H),
    .COUNT (NUM_ALIENS)
  ) u_scanner (
    .clk    (clk),
    .reset  (reset),
    .start  (scan_start),
    .step   (scan_step),
    .cx_c   (cx_c),
    .cy_c   (cy_c),
    .a_c    (a_c),
    .last_c (last_c)
  );

  // Launch decisions and the address of the pixel shown after the next edge.
  always_comb begin
    go_hit      = go_req || (gameOver && !game_over_d);
    go_launch   = (state == IDLE) && go_hit && prev_valid;
    draw_launch = (state == IDLE) && !go_hit && !gameOver && (drawEn || pending);
    req_y       = drawEn ? CounterValue : pending_y;
    into_draw   = (state == ERASE) && last_c && !erase_only;
    scan_start  = go_launch || draw_launch || into_draw;
    scan_step   = ((state == ERASE) || (state == DRAW)) && !last_c;
    unique case (state)
      IDLE:    row = (go_launch || prev_valid) ? prev_y : req_y;
      ERASE:   row = last_c ? new_y : prev_y;
      default: row = new_y;
    endcase
    pix_x = X_W'(32'(X_ORIGIN) + 32'(a_c) * 32'(SPACING) + 32'(cx_c));
    pix_y = Y_W'(32'(Y_OFFSET) + 32'(row) + 32'(cy_c));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      prev_valid  <= 1'b0;
      pending     <= 1'b0;
      go_req      <= 1'b0;
      game_over_d <= 1'b0;
      erase_only  <= 1'b0;
      prev_y      <= '0;
      new_y       <= '0;
      pending_y   <= '0;
      x           <= '0;
      y           <= '0;
      colour      <= '0;
      plot        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      game_over_d <= gameOver;
      plot        <= 1'b0;
      done        <= 1'b0;

      // One-deep request buffer for redraws that arrive during a pass.
      if (gameOver) begin
        pending <= 1'b0;
      end else if (drawEn && (state != IDLE)) begin
        pending   <= 1'b1;
        pending_y <= CounterValue;
      end
      if (gameOver && !game_over_d && (state != IDLE)) begin
        go_req <= 1'b1;
      end

      unique case (state)
        IDLE: begin
          busy <= 1'b0;
          if (go_hit) begin
            go_req <= 1'b0;
          end
          if (go_launch) begin
            erase_only <= 1'b1;
            state      <= ERASE;
            busy       <= 1'b1;
            plot       <= 1'b1;
            x          <= pix_x;
            y          <= pix_y;
            colour     <= BG_COLOUR;
          end else if (draw_launch) begin
            erase_only <= 1'b0;
            new_y      <= req_y;
            pending    <= 1'b0;
            state      <= prev_valid ? ERASE : DRAW;
            busy       <= 1'b1;
            plot       <= 1'b1;
            x          <= pix_x;
            y          <= pix_y;
            colour     <= prev_valid ? BG_COLOUR : ALIEN_COLOUR;
          end
        end
        ERASE: begin
          busy <= 1'b1;
          if (!last_c || !erase_only) begin
            plot   <= 1'b1;
            x      <= pix_x;
            y      <= pix_y;
            colour <= last_c ? ALIEN_COLOUR : BG_COLOUR;
            if (last_c) begin
              state <= DRAW;
            end
          end else begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DRAW: begin
          busy <= 1'b1;
          if (!last_c) begin
            plot   <= 1'b1;
            x      <= pix_x;
            y      <= pix_y;
            colour <= ALIEN_COLOUR;
          end else begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
          if (erase_only) begin
            prev_valid <= 1'b0;
          end else begin
            prev_valid <= 1'b1;
            prev_y     <= new_y;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alien_row_drawer.sv
// Directed and randomized bench for alien_row_drawer against a pass-level
// reference model that queues the expected per-cycle VGA outputs.
module tb_alien_row_drawer;

  logic       clk = 1'b0;
  logic       reset;
  logic       drawEn;
  logic [5:0] cv;
  logic       gameOver;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       done;

  alien_row_drawer dut (
    .clk          (clk),
    .reset        (reset),
    .drawEn       (drawEn),
    .CounterValue (cv),
    .gameOver     (gameOver),
    .x            (x),
    .y            (y),
    .colour       (colour),
    .plot         (plot),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Kinds: 0 pixel, 1 done after draw, 2 done after erase-only, 3 idle gap.
  typedef struct {
    bit plot;
    bit busy;
    bit done;
    int px;
    int py;
    int col;
    int kind;
    int ny;
  } ent_t;

  ent_t q[$];
  bit   m_pv, m_pend, m_goreq, m_goprev;
  int   m_py, m_pendy;
  logic ex_plot, ex_busy, ex_done;
  logic [7:0] ex_x;
  logic [6:0] ex_y;
  logic [2:0] ex_col;

  int cyc = 0, nplot = 0, ndone = 0, last_done = 0, t_req = 0;

  function automatic void push_pass(input int row, input int col);
    ent_t e;
    for (int a = 0; a < 8; a++)
      for (int cy = 0; cy < 4; cy++)
        for (int cx = 0; cx < 4; cx++) begin
          e = '{1, 1, 0, (16 + 16 * a + cx) % 256, (8 + row + cy) % 128, col, 0, 0};
          q.push_back(e);
        end
  endfunction

  function automatic void push_tail(input int kind, input int ny);
    ent_t e;
    e = '{0, 1, 1, 0, 0, 0, kind, ny};
    q.push_back(e);
    e = '{0, 0, 0, 0, 0, 0, 3, 0};
    q.push_back(e);
  endfunction

  function automatic void model_reset();
    q.delete();
    m_pv = 0; m_pend = 0; m_goreq = 0; m_goprev = 0; m_py = 0; m_pendy = 0;
    ex_plot = 0; ex_busy = 0; ex_done = 0; ex_x = 0; ex_y = 0; ex_col = 0;
  endfunction

  // Advance the model by one clock edge using the inputs sampled at that edge.
  function automatic void model_step();
    bit   rise;
    int   ny;
    ent_t e;
    rise = gameOver && !m_goprev;
    if (q.size() != 0) begin
      if (rise) m_goreq = 1;
      if (gameOver) m_pend = 0;
      else if (drawEn) begin m_pend = 1; m_pendy = int'(cv); end
    end else begin
      if (gameOver) m_pend = 0;
      if (m_goreq || rise) begin
        m_goreq = 0;
        if (m_pv) begin push_pass(m_py, 0); push_tail(2, 0); end
      end else if (!gameOver && (drawEn || m_pend)) begin
        ny = drawEn ? int'(cv) : m_pendy;
        m_pend = 0;
        if (m_pv) push_pass(m_py, 0);
        push_pass(ny, 2);
        push_tail(1, ny);
      end
    end
    m_goprev = gameOver;
    if (q.size() != 0) begin
      e = q.pop_front();
      ex_plot = e.plot; ex_busy = e.busy; ex_done = e.done;
      if (e.plot) begin ex_x = 8'(e.px); ex_y = 7'(e.py); ex_col = 3'(e.col); end
      if (e.kind == 1) begin m_pv = 1; m_py = e.ny; end
      if (e.kind == 2) m_pv = 0;
    end else begin
      ex_plot = 0; ex_busy = 0; ex_done = 0;
    end
  endfunction

  function automatic logic [31:0] obs();
    return {11'd0, plot, busy, done, x, y, colour};
  endfunction

  function automatic logic [31:0] expv();
    return {11'd0, ex_plot, ex_busy, ex_done, ex_x, ex_y, ex_col};
  endfunction

  task automatic tick();
    @(posedge clk);
    if (reset) model_step();
    #1;
    cyc++;
    check($sformatf("cyc%0d", cyc), obs(), expv());
    if (plot) nplot++;
    if (done) begin ndone++; last_done = cyc; end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clr_stats();
    nplot = 0; ndone = 0; last_done = 0;
  endtask

  task automatic pulse(input int v);
    t_req  = cyc;
    drawEn = 1'b1;
    cv     = 6'(v);
    tick();
    drawEn = 1'b0;
  endtask

  // Asynchronous reset in the middle of a cycle; outputs must clear at once.
  task automatic mid_reset(input string tag);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check(tag, obs(), 32'd0);
    run(2);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; drawEn = 1'b0; gameOver = 1'b0; cv = '0;
    model_reset();
    #1;
    check("reset", obs(), 32'd0);
    run(3);
    reset = 1'b1;
    run(3);

    // First pass: draw only, row 0.
    clr_stats();
    pulse(0);
    check("s1_first", {11'd0, plot, colour, x, y}, {11'd0, 1'b1, 3'b010, 8'd16, 7'd8});
    run(140);
    check("s1_plots", 32'(nplot), 32'd128);
    check("s1_done_at", 32'(last_done - t_req), 32'd129);
    check("s1_ndone", 32'(ndone), 32'd1);

    // Erase row 0 then draw row 1.
    clr_stats();
    pulse(1);
    run(265);
    check("s2_plots", 32'(nplot), 32'd256);
    check("s2_done_at", 32'(last_done - t_req), 32'd257);

    // Two requests mid-pass collapse into one extra pass at row 3.
    clr_stats();
    pulse(2);
    run(40);
    pulse(2);
    run(20);
    pulse(3);
    run(700);
    check("s3_plots", 32'(nplot), 32'd512);
    check("s3_ndone", 32'(ndone), 32'd2);

    // Game over during DRAW of row 5: finish, erase once, ignore requests.
    clr_stats();
    pulse(5);
    run(200);
    gameOver = 1'b1;
    run(100);
    pulse(7);
    run(50);
    pulse(9);
    run(400);
    check("s4_plots", 32'(nplot), 32'd384);
    check("s4_ndone", 32'(ndone), 32'd2);
    gameOver = 1'b0;
    run(5);

    // Reset during pixel 60 of a draw, then a fresh draw-only pass.
    pulse(7);
    run(60);
    mid_reset("s5_reset");
    clr_stats();
    pulse(9);
    run(140);
    check("s5_plots", 32'(nplot), 32'd128);
    check("s5_done_at", 32'(last_done - t_req), 32'd129);

    // Bottom row 40, then a repeat request at the same row.
    clr_stats();
    pulse(40);
    run(255);
    check("s6_last", {11'd0, plot, x, y}, {11'd0, 1'b1, 8'd131, 7'd51});
    run(10);
    check("s6_plots", 32'(nplot), 32'd256);
    clr_stats();
    pulse(40);
    run(265);
    check("s7_plots", 32'(nplot), 32'd256);
    check("s7_done_at", 32'(last_done - t_req), 32'd257);

    // Randomized traffic, game-over toggles and occasional resets.
    for (int i = 0; i < 4000; i++) begin
      drawEn = ($urandom % 90) == 0;
      cv     = 6'($urandom_range(0, 40));
      if (($urandom % 600) == 0) gameOver = ~gameOver;
      if (($urandom % 2000) == 0) mid_reset("rnd_reset");
      tick();
    end
    drawEn = 1'b0;
    run(600);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alien_row_drawer.md
ALIEN_ROW_DRAWER -- requirements
Module: alien_row_drawer

Interface
REQ-001 SHALL have parameters: ALIEN_W=4, alien sprite width in px; ALIEN_H=4, sprite height in px; NUM_ALIENS=8, aliens per row; SPACING=16, x pitch between aliens; X_ORIGIN=16, x of alien 0; Y_OFFSET=8, pixel y of row position 0; ALIEN_COLOUR=3'b010, draw colour; BG_COLOUR=3'b000, erase colour.
REQ-002 SHALL have ports: clk in 1, system clock; reset in 1, asynchronous active-low reset; drawEn in 1, one-cycle redraw request from the alien fall counter; CounterValue in 6, row position 0..40; gameOver in 1, level from the fall counter; x out 8, VGA pixel x; y out 7, VGA pixel y; colour out 3, VGA pixel colour; plot out 1, VGA write strobe; busy out 1, pass in progress; done out 1, one-cycle completion pulse.

Function
REQ-003 SHALL be a single clock domain, with all outputs registered.
REQ-004 SHALL implement states IDLE, ERASE, DRAW, DONE and a one-bit prev_valid flag.
REQ-005 SHALL, in IDLE when drawEn=1 and gameOver=0, latch CounterValue into new_y and enter ERASE if prev_valid=1, else DRAW.
REQ-006 SHALL scan each pass one pixel per cycle, cx fastest (0..ALIEN_W-1), then cy (0..ALIEN_H-1), then alien index a (0..NUM_ALIENS-1): 128 cycles at defaults.
REQ-007 SHALL drive x = X_ORIGIN + a*SPACING + cx and y = Y_OFFSET + row + cy, where row = prev_y in ERASE and new_y in DRAW; both are computed at full width and truncated to 8/7 bits.
REQ-008 SHALL drive plot=1 on every scan cycle, colour=BG_COLOUR in ERASE and ALIEN_COLOUR in DRAW, and plot=0 in all other states.
REQ-009 SHALL timing: request sampled at cycle t gives first plot at t+1; the last pixel of ERASE is followed directly by the first pixel of DRAW with no gap.
REQ-010 SHALL go DRAW -> DONE after the last pixel; DONE lasts 1 cycle with done=1, sets prev_y=new_y and prev_valid=1, then returns to IDLE.
REQ-011 SHALL hold busy=1 from first plot through the DONE cycle inclusive, and busy=0 otherwise.
REQ-012 SHALL, on drawEn while not IDLE, set a one-deep pending flag and overwrite pending_y with CounterValue; a later drawEn overwrites pending_y again.
REQ-013 SHALL, in IDLE with pending set, start a pass using pending_y as if drawEn had arrived, and clear pending.
REQ-014 SHALL, on gameOver rising edge in IDLE with prev_valid=1, run ERASE only, then DONE; this DONE does not update prev_y and clears prev_valid.
REQ-015 SHALL, on gameOver rising edge mid-pass, finish the current pass, then perform REQ-014.
REQ-016 SHALL ignore drawEn and clear pending while gameOver=1.
REQ-017 SHALL start a new pass on drawEn with CounterValue equal to prev_y, erasing then redrawing at the same row.

Reset
REQ-018 SHALL, on reset=0 at any time including mid-pass, immediately force IDLE, x=0, y=0, colour=0, plot=0, busy=0, done=0, prev_valid=0, pending=0, prev_y=0, new_y=0 and zero all scan counters.

Structure
REQ-019 SHALL take the sprite/grid constants, colour codes and state encoding from shared header alien_params, which the fall-counter and shot blocks also use.
REQ-020 SHALL implement the cx/cy/a nested counter as sub-module pixel_scanner, with start, step, last and index outputs.

Verification
REQ-021 SHALL check: after reset, drawEn with CounterValue=0 -> 128 plots with colour 010, first (16,8), last (131,11), done at t+129.
REQ-022 SHALL check: then drawEn with CounterValue=1 -> 128 erase plots rows 8..11 colour 000, then 128 draw plots rows 9..12, done at t+257.
REQ-023 SHALL check: drawEn mid-pass with CounterValue=2, then 3 -> exactly one further pass at row 3 starting after DONE.
REQ-024 SHALL check: gameOver rises during DRAW at row 5 -> pass completes, then one erase of rows 13..16, no draw, and later drawEn is ignored.
REQ-025 SHALL check: reset=0 asserted at pixel 60 of DRAW -> outputs zero in the same cycle; the next drawEn does a draw-only pass (128 plots).
REQ-026 SHALL check: drawEn with CounterValue=40 -> last pixel (131,51) and no y overflow.
